// File: rtl/muxn_rr_sel_pkg.sv
// rtl/muxn_rr_sel_pkg.sv - shared constants and types for the N-channel registered selector
// Contents: arbitration mode encodings and the output-register occupancy state.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Occupancy of the single-entry output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/muxn_rr_sel_if.sv
// rtl/muxn_rr_sel_if.sv - producer/consumer bundle for the N-channel registered selector
// Signals: mode/sel (arbitration control), in_data/in_valid/in_ready (NCH producer
// channels, channel k at in_data[k*WIDTH +: WIDTH]), out_data/out_ch/out_valid/out_ready
// (single consumer). master = environment side, slave = selector side.
interface muxn_rr_sel_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SELW-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/muxn_rr_sel_rr_pick.sv
// rtl/muxn_rr_sel_rr_pick.sv - combinational round-robin picker
// Ports: req (per-channel request), ptr (last granted channel),
// gnt_vld (some request present), gnt_idx (first requester after ptr, wrapping).
module rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic                   gnt_vld,
  output logic [$clog2(NCH)-1:0] gnt_idx
);
  localparam int SELW = $clog2(NCH);

  // rot[i] is the request of channel (ptr+1+i) mod NCH, so the lowest set bit
  // is the next channel in round-robin order. Modulo arithmetic keeps this
  // correct when NCH is not a power of two.
  logic [NCH-1:0]  rot;
  logic [SELW-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NCH; i++) begin
      rot[i] = req[(int'(ptr) + 1 + i) % NCH];
    end
    off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    gnt_vld = |rot;
    gnt_idx = SELW'((int'(ptr) + 1 + int'(off)) % NCH);
  end
endmodule

// File: rtl/muxn_rr_sel.sv
// rtl/muxn_rr_sel.sv - N-channel W-bit registered selector, fixed or round-robin
// Ports: clk, reset (async active-high), bus (muxn_rr_sel_if slave: mode, sel,
// in_data/in_valid/in_ready per channel, out_data/out_ch/out_valid/out_ready).
module muxn_rr_sel
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  muxn_rr_sel_if.slave bus
);
  localparam int SELW = $clog2(NCH);
  localparam int NPAD = 1 << SELW;

  out_state_t       state_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  ch_q;
  logic [SELW-1:0]  ptr_q;

  logic             load;
  logic             rr_vld;
  logic [SELW-1:0]  rr_idx;
  logic             fx_vld;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [NPAD-1:0]  valid_pad;
  logic [WIDTH-1:0] gnt_word;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Pad valids to the full sel range so an out-of-range sel reads a zero
  // instead of indexing past the vector.
  assign valid_pad = NPAD'(bus.in_valid);
  assign fx_vld    = (int'(bus.sel) < NCH) && valid_pad[bus.sel];

  // The register can take a word when empty, or when its word drains this cycle.
  assign load = (state_q == ST_EMPTY) || bus.out_ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!reset && load) begin
      if (bus.mode == MODE_RR) begin
        gnt_vld = rr_vld;
        gnt_idx = rr_idx;
      end else begin
        gnt_vld = fx_vld;
        gnt_idx = bus.sel;
      end
    end
  end

  // A grant implies the channel is valid, so grant == transfer.
  assign bus.in_ready = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
  assign gnt_word     = bus.in_data[int'(gnt_idx) * WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= SELW'(NCH - 1);
    end else if (load) begin
      if (gnt_vld) begin
        state_q <= ST_FULL;
        data_q  <= gnt_word;
        ch_q    <= gnt_idx;
        ptr_q   <= gnt_idx;
      end else begin
        // Drained with nothing to replace it; data/channel keep last values.
        state_q <= ST_EMPTY;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_muxn_rr_sel.sv
// tb/tb_muxn_rr_sel.sv - self-checking bench for muxn_rr_sel
module tb_muxn_rr_sel;
  import mux_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muxn_rr_sel_if #(.WIDTH(W), .NCH(N))  b4 ();
  muxn_rr_sel_if #(.WIDTH(W), .NCH(N3)) b3 ();

  muxn_rr_sel #(.WIDTH(W), .NCH(N))  dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  muxn_rr_sel #(.WIDTH(W), .NCH(N3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model for the 4-channel instance: register contents and last grant.
  logic         m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_ch   = 0;
  int           m_ptr  = N - 1;

  // Granted channel under the current inputs, or -1.
  function automatic int model_grant();
    if (reset) return -1;
    if (m_full && !b4.out_ready) return -1;
    if (b4.mode == MODE_FIXED)
      return (int'(b4.sel) < N && b4.in_valid[b4.sel]) ? int'(b4.sel) : -1;
    for (int s = 1; s <= N; s++) begin
      if (b4.in_valid[(m_ptr + s) % N]) return (m_ptr + s) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = model_grant();
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_full <= 1'b0;
      m_data <= '0;
      m_ch   <= 0;
      m_ptr  <= N - 1;
    end else if (!m_full || b4.out_ready) begin
      if (model_grant() >= 0) begin
        m_full <= 1'b1;
        m_ch   <= model_grant();
        m_ptr  <= model_grant();
        m_data <= b4.in_data[model_grant() * W +: W];
      end else begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready",  b4.in_ready,  exp_ready());
    check("cyc_out_valid", b4.out_valid, m_full);
    check("cyc_out_data",  b4.out_data,  m_data);
    check("cyc_out_ch",    b4.out_ch,    m_ch);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int             rr_seq[6]  = '{0, 1, 2, 3, 0, 1};
  int             sp_seq[3]  = '{1, 3, 1};
  logic [N-1:0]   sp_rdy[3]  = '{4'b0010, 4'b1000, 4'b0010};
  int             rr3_seq[4] = '{0, 1, 2, 0};

  initial begin
    reset        = 1'b1;
    b4.mode      = MODE_RR;
    b4.sel       = '0;
    b4.in_valid  = '1;
    b4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    b4.out_ready = 1'b1;
    b3.mode      = MODE_FIXED;
    b3.sel       = '0;
    b3.in_valid  = '0;
    b3.in_data   = 24'h332211;
    b3.out_ready = 1'b1;

    cyc();
    cyc();
    #1;
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_data",  b4.out_data,  0);
    check("rst_out_ch",    b4.out_ch,    0);
    check("rst_in_ready",  b4.in_ready,  4'b0000);
    reset = 1'b0;
    #1;
    check("rst_first_rr_gnt", b4.in_ready, 4'b0001);

    for (int i = 0; i < 6; i++) begin
      cyc();
      check("rr_seq_ch",    b4.out_ch,    rr_seq[i]);
      check("rr_seq_valid", b4.out_valid, 1);
    end

    b4.mode    = MODE_FIXED;
    b4.sel     = 2'd2;
    b4.in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    #1;
    check("fix_in_ready", b4.in_ready, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("fix_out_data", b4.out_data, 8'hA5);
      check("fix_out_ch",   b4.out_ch,   2);
    end

    b4.sel = 2'd1;
    cyc();
    check("bp_setup_ch", b4.out_ch, 1);
    b4.mode      = MODE_RR;
    b4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", b4.in_ready, 4'b0000);
      cyc();
      check("bp_hold_ch",   b4.out_ch,   1);
      check("bp_hold_data", b4.out_data, 8'h11);
    end
    b4.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", b4.in_ready, 4'b0100);
    cyc();
    check("bp_release_ch", b4.out_ch, 2);

    b4.in_valid = 4'b1000;
    cyc();
    check("sp_setup_ch", b4.out_ch, 3);
    b4.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sp_in_ready", b4.in_ready, sp_rdy[i]);
      cyc();
      check("sp_out_ch", b4.out_ch, sp_seq[i]);
    end
    b4.in_valid = 4'b0000;
    #1;
    check("sp_none_rdy", b4.in_ready, 4'b0000);
    cyc();
    check("sp_drain_valid", b4.out_valid, 0);
    check("sp_drain_ch",    b4.out_ch,    1);

    b4.in_valid = 4'b1111;
    b3.sel      = 2'd3;
    b3.in_valid = 3'b111;
    #1;
    check("n3_sel3_rdy", b3.in_ready, 3'b000);
    cyc();
    cyc();
    check("n3_sel3_valid", b3.out_valid, 0);
    b3.sel = 2'd2;
    cyc();
    check("n3_fix_valid", b3.out_valid, 1);
    check("n3_fix_ch",    b3.out_ch,    2);
    check("n3_fix_data",  b3.out_data,  8'h33);
    b3.out_ready = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    check("n3_async_rst_valid", b3.out_valid, 0);
    check("n4_async_rst_valid", b4.out_valid, 0);
    cyc();
    reset        = 1'b0;
    b3.mode      = MODE_RR;
    b3.out_ready = 1'b1;
    #1;
    check("n3_rr_first_rdy", b3.in_ready, 3'b001);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("n3_rr_ch", b3.out_ch, rr3_seq[i]);
    end

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      b4.mode      = 1'($urandom_range(0, 1));
      b4.sel       = 2'($urandom);
      b4.in_valid  = 4'($urandom);
      b4.in_data   = $urandom;
      b4.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
